vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Drives the pixel coordinate and visible-area strobe consumed by the map/sprite renderers (map_x/map_y/map_on side).
- Samples the renderer's combinational 12-bit colour and drives the registered, blank-gated colour and the sync pins to the DAC/connector.

Parameters:
- CLK_DIV, 4: system clocks per pixel; legal range 1..16; 4 gives a 25 MHz pixel rate from 100 MHz.
- H_DISPLAY, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rgb_in  in  12  colour from the renderer for the current pixel_x/pixel_y, in {R[11:8],G[7:4],B[3:0]} order.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- video_on  out  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY.
- p_tick  out  1  one-clk pixel-enable strobe.
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0).
- hsync  out  1  registered, active-low horizontal sync.
- vsync  out  1  registered, active-low vertical sync.
- vga_rgb  out  12  registered pixel colour; 0 while blanked.

Behaviour:
- H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP = 525.
- Divider: div_cnt runs 0..CLK_DIV-1 and wraps. p_tick = (div_cnt==CLK_DIV-1). With CLK_DIV=1, p_tick is held high.
- Horizontal counter: h_cnt advances only on p_tick. At H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt advances only on a p_tick where h_cnt==H_TOTAL-1. At V_TOTAL-1 it wraps to 0. Both counters wrap on the same tick at end of frame.
- pixel_x/pixel_y are driven directly from h_cnt/v_cnt registers. They stay stable for CLK_DIV clocks, which gives the renderer CLK_DIV-1 clocks of combinational slack.
- video_on is combinational from the counter registers.
- Sync windows (next-state, combinational):
  - hs_n = 0 when h_cnt in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1], i.e. 656..751.
  - vs_n = 0 when v_cnt in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1], i.e. 490..491.
- Output stage, loaded only on p_tick:
  - hsync <= hs_n; vsync <= vs_n.
  - vga_rgb <= video_on ? rgb_in : 12'h000.
  - Output pins therefore lag pixel_x/pixel_y by exactly one pixel period. Syncs and colour are mutually aligned.
  - Between p_ticks, all output-stage registers hold.
- frame_start is registered. It is high for exactly one clk, the clk after the p_tick on which (h_cnt,v_cnt) goes from (799,524) to (0,0).
- Reset values (asynchronous, immediate on rst_n low): div_cnt=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1, vga_rgb=0, frame_start=0, p_tick=0 (CLK_DIV>1).
  - video_on reads 1 during reset because (0,0) is visible.
- Reset deassertion: first p_tick occurs on the CLK_DIV-th rising edge after rst_n rises.
- Reset mid-frame: counters and outputs return to reset values at once, with no partial line emitted. Timing restarts from (0,0).
- rgb_in is ignored outside p_tick and outside the visible area. Blanking is never skipped, even if rgb_in is non-zero.
- No other inputs; no stall or back-pressure path.

Test Plan:
- Reset release with CLK_DIV=4 -> p_tick first high on the 4th clk edge, then every 4 clks. pixel_x steps 0,1,2 on successive ticks. hsync=vsync=1 and vga_rgb=0 throughout reset.
- Run one full line with rgb_in=12'hABC -> on the ticks while pixel_x=0..639, vga_rgb samples 12'hABC (pins one pixel later). vga_rgb=0 on the tick after pixel_x reaches 640. hsync is low for exactly 96 ticks, first low on the tick after pixel_x=656. Line length is 800 ticks.
- Run one full frame -> vsync is low for exactly 2 lines, starting one tick after (0,490). frame_start pulses exactly once, 800*525=420000 ticks apart. video_on is high for exactly 640*480=307200 ticks per frame.
- Wrap boundary: at (799,524) a tick gives (0,0) with both counters wrapping together, and frame_start is high for one clk. At (799,10) a tick gives (0,11).
- Assert rst_n low at (300,200) -> all outputs take reset values asynchronously, without waiting for a clk edge. On release, counting restarts at (0,0) with no glitch on hsync/vsync.
- CLK_DIV=1 -> p_tick is constantly high and a frame completes in 420000 clks. Drive rgb_in=12'hFFF during blanking -> vga_rgb stays 0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing: pixel-rate divider, h/v scan counters and a
// one-pixel-deep registered output stage for the sync pins and blank-gated colour.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        p_tick,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] vga_rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;
  logic             hsync_r;
  logic             vsync_r;
  logic [11:0]      vga_rgb_r;
  logic             frame_start_r;

  logic p_tick_s;
  logic h_end_s;
  logic v_end_s;
  logic video_on_s;
  logic hs_n_s;
  logic vs_n_s;

  // Decode tick, line/frame ends, visible area and next-state sync levels.
  always_comb begin
    // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so the tick is held high.
    p_tick_s   = (div_cnt_r == DIV_LAST);
    h_end_s    = (h_cnt_r == H_LAST);
    v_end_s    = (v_cnt_r == V_LAST);
    video_on_s = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
    hs_n_s     = !((h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST));
    vs_n_s     = !((v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST));
  end

  // System-clock to pixel-rate divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Horizontal and vertical scan counters; both wrap on the same tick at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (p_tick_s) begin
      if (h_end_s) begin
        h_cnt_r <= 10'd0;
        if (v_end_s) begin
          v_cnt_r <= 10'd0;
        end else begin
          v_cnt_r <= v_cnt_r + 10'd1;
        end
      end else begin
        h_cnt_r <= h_cnt_r + 10'd1;
      end
    end
  end

  // Pin stage: sample syncs and gated colour once per pixel, one pixel behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_r   <= 1'b1;
      vsync_r   <= 1'b1;
      vga_rgb_r <= 12'h000;
    end else if (p_tick_s) begin
      hsync_r   <= hs_n_s;
      vsync_r   <= vs_n_s;
      vga_rgb_r <= video_on_s ? rgb_in : 12'h000;
    end
  end

  // Frame-start pulse for the clock following the (last,last) -> (0,0) wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= p_tick_s && h_end_s && v_end_s;
    end
  end

  assign pixel_x     = h_cnt_r;
  assign pixel_y     = v_cnt_r;
  assign video_on    = video_on_s;
  assign p_tick      = p_tick_s;
  assign frame_start = frame_start_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign vga_rgb     = vga_rgb_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size CLK_DIV=4 instance for line-level timing and
// a tiny CLK_DIV=1 instance for frame-level behaviour, both against a closed-form model.
module tb_vga_sync_gen;

  localparam int A_D = 4, A_HD = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
  localparam int A_VD = 480, A_VFP = 10, A_VS = 2, A_VBP = 33;
  localparam int B_D = 1, B_HD = 8, B_HFP = 2, B_HS = 3, B_HBP = 2;
  localparam int B_VD = 6, B_VFP = 1, B_VS = 2, B_VBP = 1;
  localparam int A_HT = 800, A_VT = 525, B_HT = 15, B_VT = 10;

  logic clk;
  logic rst_n;
  logic [11:0] rgb_a, rgb_b;
  logic [9:0]  px_a, py_a, px_b, py_b;
  logic        von_a, pt_a, fs_a, hs_a, vs_a;
  logic        von_b, pt_b, fs_b, hs_b, vs_b;
  logic [11:0] rgbo_a, rgbo_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ca, cb;
  logic [11:0] la, lb;

  vga_sync_gen #(.CLK_DIV(A_D), .H_DISPLAY(A_HD), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
                 .V_DISPLAY(A_VD), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP)) dut_a (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_a), .pixel_x(px_a), .pixel_y(py_a),
    .video_on(von_a), .p_tick(pt_a), .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a),
    .vga_rgb(rgbo_a));

  vga_sync_gen #(.CLK_DIV(B_D), .H_DISPLAY(B_HD), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
                 .V_DISPLAY(B_VD), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)) dut_b (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_b), .pixel_x(px_b), .pixel_y(py_b),
    .video_on(von_b), .p_tick(pt_b), .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b),
    .vga_rgb(rgbo_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit vis(input int n, input int ht, input int vt, input int hd, input int vd);
    return ((n % ht) < hd) && (((n / ht) % vt) < vd);
  endfunction

  // Reference state: clocks since reset release and the colour due on the pins.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca <= 0; cb <= 0; la <= 12'h000; lb <= 12'h000;
    end else begin
      ca <= ca + 1;
      cb <= cb + 1;
      if ((ca + 1) % A_D == 0) la <= vis(ca / A_D, A_HT, A_VT, A_HD, A_VD) ? rgb_a : 12'h000;
      if ((cb + 1) % B_D == 0) lb <= vis(cb / B_D, B_HT, B_VT, B_HD, B_VD) ? rgb_b : 12'h000;
    end
  end

  task automatic cmp_inst(input string t, input int c, input int d,
                          input int hd, input int hfp, input int hsw, input int hbp,
                          input int vd, input int vfp, input int vsw, input int vbp,
                          input logic [11:0] l, input logic [9:0] px, input logic [9:0] py,
                          input logic von, input logic pt, input logic fs,
                          input logic hsy, input logic vsy, input logic [11:0] rgb);
    int ht = hd + hfp + hsw + hbp;
    int vt = vd + vfp + vsw + vbp;
    int n  = c / d;
    int x  = n % ht;
    int y  = (n / ht) % vt;
    int pp = n - 1;
    int ehs = 1;
    int evs = 1;
    if (n > 0) begin
      ehs = !(((pp % ht) >= hd + hfp) && ((pp % ht) < hd + hfp + hsw));
      evs = !((((pp / ht) % vt) >= vd + vfp) && (((pp / ht) % vt) < vd + vfp + vsw));
    end
    chk({t, ".pixel_x"}, px, x);
    chk({t, ".pixel_y"}, py, y);
    chk({t, ".video_on"}, von, (x < hd) && (y < vd));
    chk({t, ".p_tick"}, pt, ((c + 1) % d) == 0);
    chk({t, ".frame_start"}, fs, (c > 0) && (c % d == 0) && (n % (ht * vt) == 0));
    chk({t, ".hsync"}, hsy, ehs);
    chk({t, ".vsync"}, vsy, evs);
    chk({t, ".vga_rgb"}, rgb, l);
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      cmp_inst("a", ca, A_D, A_HD, A_HFP, A_HS, A_HBP, A_VD, A_VFP, A_VS, A_VBP,
               la, px_a, py_a, von_a, pt_a, fs_a, hs_a, vs_a, rgbo_a);
      cmp_inst("b", cb, B_D, B_HD, B_HFP, B_HS, B_HBP, B_VD, B_VFP, B_VS, B_VBP,
               lb, px_b, py_b, von_b, pt_b, fs_b, hs_b, vs_b, rgbo_b);
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    rgb_b = {4'hF, cyc[7:0]};
  endtask

  function automatic bit at_pos(input int sel, input int x, input int y);
    if (sel == 0) return (int'(px_a) == x) && (int'(py_a) == y);
    else          return (int'(px_b) == x) && (int'(py_b) == y);
  endfunction

  task automatic wait_pos(input int sel, input int x, input int y, input int budget, input string name);
    int k = 0;
    while (!at_pos(sel, x, y) && k < budget) begin
      step();
      k++;
    end
    chk(name, at_pos(sel, x, y), 1);
  endtask

  initial begin
    int k, c0, lowc, vcnt, vsl, fsc;
    rst_n = 1'b1;
    rgb_a = 12'h000;
    rgb_b = 12'hFFF;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_hsync", hs_a, 1);
    chk("rst_vsync", vs_a, 1);
    chk("rst_rgb", rgbo_a, 0);
    chk("rst_video_on", von_a, 1);
    chk("rst_p_tick_a", pt_a, 0);
    chk("rst_p_tick_b", pt_b, 1);

    // Release: first tick lands on the 4th edge.
    rst_n = 1'b1;
    repeat (3) step();
    chk("edge3_p_tick", pt_a, 1);
    chk("edge3_x", px_a, 0);
    step();
    chk("edge4_x", px_a, 1);
    chk("edge4_p_tick", pt_a, 0);
    repeat (4) step();
    chk("edge8_x", px_a, 2);

    rgb_a = 12'hABC;
    wait_pos(0, 640, 0, 3000, "reach_640");
    chk("rgb_last_visible", rgbo_a, 12'hABC);
    wait_pos(0, 641, 0, 10, "reach_641");
    chk("rgb_first_blank", rgbo_a, 12'h000);
    wait_pos(0, 656, 0, 100, "reach_656");
    chk("hsync_before", hs_a, 1);
    wait_pos(0, 657, 0, 10, "reach_657");
    chk("hsync_first_low", hs_a, 0);
    wait_pos(0, 0, 1, 1000, "reach_line1");
    chk("line1_hsync", hs_a, 1);
    chk("line1_rgb", rgbo_a, 12'h000);

    // One full line: count clocks and hsync-low clocks.
    c0 = cyc; lowc = 0; k = 0;
    while (!(px_a == 10'd0 && py_a == 10'd2) && k < 4000) begin
      step();
      k++;
      if (!hs_a) lowc++;
    end
    chk("line_clocks", cyc - c0, A_HT * A_D);
    chk("hsync_low_clocks", lowc, A_HS * A_D);

    // Asynchronous reset in mid-line.
    wait_pos(0, 300, 2, 2000, "reach_300_2");
    chk("pre_reset_rgb", rgbo_a, 12'hABC);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_x", px_a, 0);
    chk("async_y", py_a, 0);
    chk("async_rgb", rgbo_a, 0);
    chk("async_hsync", hs_a, 1);
    chk("async_vsync", vs_a, 1);
    chk("async_fs", fs_a, 0);
    chk("async_b_x", px_b, 0);
    repeat (3) step();
    rst_n = 1'b1;

    // Frame-level behaviour on the small instance.
    k = 0;
    while (fs_b !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    chk("fs_b_seen", fs_b, 1);
    vcnt = 0; vsl = 0; fsc = 0;
    for (int i = 0; i < B_HT * B_VT; i++) begin
      if (von_b) vcnt++;
      if (!vs_b) vsl++;
      if (fs_b) fsc++;
      step();
    end
    chk("fs_b_period", fs_b, 1);
    chk("video_on_count", vcnt, 48);
    chk("vsync_low_count", vsl, 30);
    chk("fs_pulses", fsc, 1);

    wait_pos(1, 0, 7, 200, "b_reach_0_7");
    chk("b_vsync_pre", vs_b, 1);
    step();
    chk("b_vsync_low", vs_b, 0);
    wait_pos(1, 14, 9, 200, "b_reach_14_9");
    step();
    chk("b_wrap_x", px_b, 0);
    chk("b_wrap_y", py_b, 0);
    chk("b_wrap_fs", fs_b, 1);
    step();
    chk("b_fs_one_clk", fs_b, 0);
    wait_pos(1, 14, 1, 200, "b_reach_14_1");
    step();
    chk("b_line_wrap_x", px_b, 0);
    chk("b_line_wrap_y", py_b, 2);
    wait_pos(1, 9, 0, 200, "b_reach_9_0");
    chk("b_blank_rgb", rgbo_b, 12'h000);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
